// File: rtl/uni_shift_if.sv
// uni_shift_if
//   Command/status bundle between a host control FSM and uni_shift_engine.
//   master : host side (drives start/mode/amount/data_in/serial fills)
//   slave  : engine side (drives data_out, serial outs, busy, done)
interface uni_shift_if #(
  parameter int N     = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [2:0]       mode;
  logic [CNT_W-1:0] amount;
  logic [N-1:0]     data_in;
  logic             ser_in_l;
  logic             ser_in_r;
  logic [N-1:0]     data_out;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, amount, data_in, ser_in_l, ser_in_r,
    input  data_out, ser_out_l, ser_out_r, busy, done
  );

  modport slave (
    input  start, mode, amount, data_in, ser_in_l, ser_in_r,
    output data_out, ser_out_l, ser_out_r, busy, done
  );
endinterface

// File: rtl/uni_shift_engine.sv
// uni_shift_engine
//   Multi-cycle universal shift engine: logical/arithmetic shifts and rotates
//   by a programmed amount, one bit per clock, plus parallel load/clear/hold.
//   Commands use a start/busy/done handshake.
// Ports
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : uni_shift_if slave modport (command inputs, data/status outputs)
module uni_shift_engine #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  uni_shift_if.slave  bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SLL   = 3'b001;
  localparam logic [2:0] M_SRL   = 3'b010;
  localparam logic [2:0] M_SRA   = 3'b011;
  localparam logic [2:0] M_ROL   = 3'b100;
  localparam logic [2:0] M_ROR   = 3'b101;
  localparam logic [2:0] M_LOAD  = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);

  // One single-bit step of the selected shift/rotate; non-shift modes pass through.
  function automatic logic [N-1:0] shift_step(
    input logic [2:0]   m,
    input logic [N-1:0] d,
    input logic         fill_l,
    input logic         fill_r
  );
    logic [N-1:0] r;
    case (m)
      M_SLL:   r = {d[N-2:0], fill_r};
      M_SRL:   r = {fill_l, d[N-1:1]};
      M_SRA:   r = {d[N-1], d[N-1:1]};
      M_ROL:   r = {d[N-2:0], d[N-1]};
      M_ROR:   r = {d[0], d[N-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     data_q,  data_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;   // shifts still to perform after the current edge
  logic [2:0]       mode_q,  mode_d;  // command captured at acceptance
  logic             done_q,  done_d;
  logic [CNT_W-1:0] k_s;
  logic             is_shift_s;

  // Effective shift count (saturated at N) and shift-mode decode of the live command.
  always_comb begin
    k_s        = (bus.amount > CNT_N) ? CNT_N : bus.amount;
    is_shift_s = (bus.mode >= M_SLL) && (bus.mode <= M_ROR);
  end

  // Next-state logic for the command FSM, data register and counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (is_shift_s && (k_s != CNT_ZERO)) begin
            data_d = shift_step(bus.mode, data_q, bus.ser_in_l, bus.ser_in_r);
            if (k_s == CNT_ONE) begin
              done_d = 1'b1;
            end else begin
              // First shift happens here; remaining k-1 edges run in SHIFT.
              state_d = S_SHIFT;
              cnt_d   = k_s - CNT_ONE;
              mode_d  = bus.mode;
            end
          end else begin
            case (bus.mode)
              M_LOAD:  data_d = bus.data_in;
              M_CLEAR: data_d = {N{1'b0}};
              M_HOLD:  data_d = data_q;
              default: data_d = data_q;  // shift mode with k=0
            endcase
            done_d = 1'b1;
          end
        end else begin
          data_d = data_q;
        end
      end
      S_SHIFT: begin
        // start is ignored here; serial fills are sampled live each edge.
        data_d = shift_step(mode_q, data_q, bus.ser_in_l, bus.ser_in_r);
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State registers with asynchronous active-low reset; reset abandons any command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= {N{1'b0}};
      cnt_q   <= CNT_ZERO;
      mode_q  <= M_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.ser_out_l = data_q[N-1];
  assign bus.ser_out_r = data_q[0];
  assign bus.busy      = (state_q == S_SHIFT);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_uni_shift_engine.sv
module tb_uni_shift_engine;
  logic clk;
  logic reset;
  int tests_run;
  int tests_failed;

  uni_shift_if #(.N(8), .CNT_W(4)) bus ();

  uni_shift_engine #(.N(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a command for one acceptance edge; returns at the negedge after T0.
  task automatic issue(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mode    = m;
    bus.amount  = a;
    bus.data_in = d;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", bus.busy, bus.done); end
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load();
    issue(3'b110, 4'd0, 8'hCC);
    tests_run++;
    if (bus.data_out !== 8'hCC || bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL load: data=%h done=%b busy=%b want cc 1 0", bus.data_out, bus.done, bus.busy); end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL load_done_pulse: done=%b want 0", bus.done); end
  endtask

  task automatic test_sll();
    bus.ser_in_r = 1'b1;
    issue(3'b001, 4'd3, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h99 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin tests_failed++;
      $display("FAIL sll_step1: data=%h busy=%b done=%b want 99 1 0", bus.data_out, bus.busy, bus.done); end
    @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'h33 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin tests_failed++;
      $display("FAIL sll_step2: data=%h busy=%b done=%b want 33 1 0", bus.data_out, bus.busy, bus.done); end
    @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'h67 || bus.busy !== 1'b0 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL sll_step3: data=%h busy=%b done=%b want 67 0 1", bus.data_out, bus.busy, bus.done); end
    tests_run++;
    if (bus.ser_out_l !== 1'b0 || bus.ser_out_r !== 1'b1) begin tests_failed++;
      $display("FAIL ser_out: l=%b r=%b want 0 1", bus.ser_out_l, bus.ser_out_r); end
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL sll_done_pulse: done=%b want 0", bus.done); end
    bus.ser_in_r = 1'b0;
  endtask

  task automatic test_sra_ror();
    issue(3'b110, 4'd0, 8'h80);
    issue(3'b011, 4'd2, 8'h00);
    @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'hE0 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL sra: data=%h done=%b want e0 1", bus.data_out, bus.done); end
    issue(3'b110, 4'd0, 8'h01);
    issue(3'b101, 4'd1, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h80 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL ror1: data=%h done=%b busy=%b want 80 1 0", bus.data_out, bus.done, bus.busy); end
  endtask

  task automatic test_rol_saturate();
    int busy_cycles;
    issue(3'b110, 4'd0, 8'hA5);
    issue(3'b100, 4'd12, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h4B) begin tests_failed++; $display("FAIL rol_step1: data=%h want 4b", bus.data_out); end
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 20) begin
      busy_cycles++;
      @(negedge clk);
    end
    tests_run++;
    if (busy_cycles != 7) begin tests_failed++; $display("FAIL rol_busy_len: got %0d want 7", busy_cycles); end
    tests_run++;
    if (bus.data_out !== 8'hA5 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL rol_final: data=%h done=%b want a5 1", bus.data_out, bus.done); end
  endtask

  task automatic test_start_while_busy();
    issue(3'b110, 4'd0, 8'h3C);
    bus.ser_in_l = 1'b0;
    issue(3'b010, 4'd4, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h1E || bus.busy !== 1'b1) begin tests_failed++;
      $display("FAIL srl_step1: data=%h busy=%b want 1e 1", bus.data_out, bus.busy); end
    bus.start = 1'b1; bus.mode = 3'b110; bus.data_in = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.data_out !== 8'h0F || bus.busy !== 1'b1) begin tests_failed++;
      $display("FAIL srl_ignore_start: data=%h busy=%b want 0f 1", bus.data_out, bus.busy); end
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'h03 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL srl_final: data=%h done=%b busy=%b want 03 1 0", bus.data_out, bus.done, bus.busy); end
    issue(3'b001, 4'd0, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h03 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL sll_zero: data=%h done=%b busy=%b want 03 1 0", bus.data_out, bus.done, bus.busy); end
  endtask

  task automatic test_hold_clear();
    issue(3'b000, 4'd5, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h03 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL hold: data=%h done=%b want 03 1", bus.data_out, bus.done); end
    issue(3'b111, 4'd0, 8'h00);
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL clear: data=%h done=%b want 00 1", bus.data_out, bus.done); end
  endtask

  task automatic test_back_to_back();
    issue(3'b110, 4'd0, 8'h81);
    // Next command presented in the done cycle: accepted with no dead cycle.
    bus.start = 1'b1; bus.mode = 3'b100; bus.amount = 4'd1;
    @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'h03 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL b2b_first: data=%h done=%b want 03 1", bus.data_out, bus.done); end
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++;
    if (bus.data_out !== 8'h06 || bus.done !== 1'b1) begin tests_failed++;
      $display("FAIL b2b_second: data=%h done=%b want 06 1", bus.data_out, bus.done); end
  endtask

  task automatic test_reset_abort();
    issue(3'b110, 4'd0, 8'hFF);
    bus.ser_in_l = 1'b0;
    issue(3'b010, 4'd5, 8'h00);
    @(negedge clk);
    tests_run++;
    if (bus.data_out !== 8'h3F || bus.busy !== 1'b1) begin tests_failed++;
      $display("FAIL abort_pre: data=%h busy=%b want 3f 1", bus.data_out, bus.busy); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.data_out !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin tests_failed++;
      $display("FAIL abort_reset: data=%h busy=%b done=%b want 00 0 0", bus.data_out, bus.busy, bus.done); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done: done=%b want 0", bus.done); end
    end
    reset = 1'b1;
    issue(3'b110, 4'd0, 8'h3C);
    tests_run++;
    if (bus.data_out !== 8'h3C || bus.done !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL abort_reload: data=%h done=%b busy=%b want 3c 1 0", bus.data_out, bus.done, bus.busy); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    bus.start    = 1'b1;
    bus.mode     = 3'b110;
    bus.amount   = 4'd0;
    bus.data_in  = 8'hCC;
    bus.ser_in_l = 1'b0;
    bus.ser_in_r = 1'b0;
    test_reset();
    test_load();
    test_sll();
    test_sra_ror();
    test_rol_saturate();
    test_start_while_busy();
    test_hold_clear();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
